// File: rtl/rvvi_trace_pkg.sv
// Shared trace record type and record-building helper for the RVVI trace FIFO.
// Optional feature macro used by the top level: RVVI_ORDER_CHECK_EN.
package rvvi_trace_pkg;

  localparam int REC_ORDER_W = 64;

  typedef struct packed {
    logic [REC_ORDER_W-1:0] order;
    logic [31:0]            pc;
    logic [31:0]            insn;
    logic                   trap;
    logic [4:0]             rd_addr;
    logic                   wb;
    logic [31:0]            wdata;
  } trace_rec_t;

  // Writes to x0 are architecturally invisible, so they are recorded as no write-back.
  function automatic trace_rec_t make_rec(
    input logic [REC_ORDER_W-1:0] order,
    input logic [31:0]            pc,
    input logic [31:0]            insn,
    input logic                   trap,
    input logic [4:0]             rd_addr,
    input logic [31:0]            wdata
  );
    trace_rec_t rec;
    rec.order   = order;
    rec.pc      = pc;
    rec.insn    = insn;
    rec.trap    = trap;
    rec.rd_addr = rd_addr;
    rec.wb      = (rd_addr != 5'd0);
    rec.wdata   = (rd_addr != 5'd0) ? wdata : 32'd0;
    return rec;
  endfunction

endpackage

// File: rtl/rvvi_trace_fifo_storage.sv
// trace_fifo: generic synchronous show-ahead FIFO with wrap-bit pointers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty;
  logic             pop_fire;
  logic             push_fire;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_fire  = pop && !empty;
  assign push_fire = push && (!full || pop_fire);
  assign valid     = !empty;
  assign count     = wr_ptr - rd_ptr;

  // Empty FIFO presents an all-zero head so the output never carries stale data.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop_fire)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_fire) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rvvi_trace_fifo.sv
// RVVI retirement trace buffer: record FIFO, overflow/drop accounting and an
// optional retirement-order gap checker enabled by RVVI_ORDER_CHECK_EN.
module rvvi_trace_fifo
  import rvvi_trace_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ORDER_W = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     ret_valid_i,
  input  logic [ORDER_W-1:0]       ret_order_i,
  input  logic [31:0]              ret_pc_i,
  input  logic [31:0]              ret_insn_i,
  input  logic                     ret_trap_i,
  input  logic [4:0]               ret_rd_addr_i,
  input  logic [31:0]              ret_rd_wdata_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output trace_rec_t               out_rec_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o,
  output logic                     order_err_o,
  output logic [ORDER_W-1:0]       err_order_o
);

  trace_rec_t in_rec;
  logic       full;
  logic       drop;

  assign in_rec = make_rec(REC_ORDER_W'(ret_order_i), ret_pc_i, ret_insn_i,
                           ret_trap_i, ret_rd_addr_i, ret_rd_wdata_i);

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(trace_rec_t))
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .push  (ret_valid_i),
    .wdata (in_rec),
    .pop   (out_ready_i),
    .rdata (out_rec_o),
    .valid (out_valid_o),
    .full  (full),
    .count (count_o)
  );

  assign drop = ret_valid_i && full && !(out_ready_i && out_valid_o);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= 16'd0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

`ifdef RVVI_ORDER_CHECK_EN
  logic               armed;
  logic [ORDER_W-1:0] expected;

  // Every retirement, dropped or not, re-baselines the expected order.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      armed       <= 1'b0;
      expected    <= '0;
      order_err_o <= 1'b0;
      err_order_o <= '0;
    end else if (ret_valid_i) begin
      armed    <= 1'b1;
      expected <= ret_order_i + {{(ORDER_W-1){1'b0}}, 1'b1};
      if (armed && (ret_order_i != expected)) begin
        order_err_o <= 1'b1;
        if (!order_err_o) err_order_o <= ret_order_i;
      end
    end
  end
`else
  assign order_err_o = 1'b0;
  assign err_order_o = '0;
`endif

endmodule

// File: tb/tb_rvvi_trace_fifo.sv
// Directed-vector bench for rvvi_trace_fifo (DEPTH=8); order-gap expectations
// follow RVVI_ORDER_CHECK_EN.
module tb_rvvi_trace_fifo;
  import rvvi_trace_pkg::*;

  localparam logic [31:0] INSN = 32'h0050_0293;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ret_valid = 1'b0;
  logic [63:0]      ret_order = '0;
  logic [31:0]      ret_pc = '0;
  logic [31:0]      ret_insn = INSN;
  logic             ret_trap = 1'b0;
  logic [4:0]       ret_rd_addr = '0;
  logic [31:0]      ret_rd_wdata = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  trace_rec_t       out_rec;
  logic [3:0]       count;
  logic             overflow;
  logic [15:0]      drop_cnt;
  logic             order_err;
  logic [63:0]      err_order;

  int vectors = 0;
  int miscompares = 0;

  rvvi_trace_fifo #(.DEPTH(8), .ORDER_W(64)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .ret_valid_i    (ret_valid),
    .ret_order_i    (ret_order),
    .ret_pc_i       (ret_pc),
    .ret_insn_i     (ret_insn),
    .ret_trap_i     (ret_trap),
    .ret_rd_addr_i  (ret_rd_addr),
    .ret_rd_wdata_i (ret_rd_wdata),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_rec_o      (out_rec),
    .count_o        (count),
    .overflow_o     (overflow),
    .drop_cnt_o     (drop_cnt),
    .order_err_o    (order_err),
    .err_order_o    (err_order)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] ord, input logic [31:0] pc,
                               input logic [4:0] rd, input logic [31:0] wd, input logic rdy);
    ret_valid    = v;
    ret_order    = ord;
    ret_pc       = pc;
    ret_rd_addr  = rd;
    ret_rd_wdata = wd;
    out_ready    = rdy;
    step();
  endtask

  logic [63:0] drain_orders [8];
  logic        exp_err;

  initial begin
    drain_orders = '{64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8, 64'd9, 64'd12};
`ifdef RVVI_ORDER_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    step();
    step();
    rst_n = 1'b1;
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_drop", 64'(drop_cnt), 64'd0);
    checkOutput("rst_order_err", 64'(order_err), 64'd0);
    checkOutput("rst_rec_zero", 64'(|out_rec), 64'd0);

    // Single retire with consumer ready: visible next cycle, then drained.
    ret_trap = 1'b0;
    applyStimulus(1'b1, 64'd0, 32'h8000_0000, 5'd5, 32'h1234, 1'b1);
    checkOutput("t1_valid", 64'(out_valid), 64'd1);
    checkOutput("t1_count", 64'(count), 64'd1);
    checkOutput("t1_order", out_rec.order, 64'd0);
    checkOutput("t1_pc", 64'(out_rec.pc), 64'h8000_0000);
    checkOutput("t1_insn", 64'(out_rec.insn), 64'(INSN));
    checkOutput("t1_rd", 64'(out_rec.rd_addr), 64'd5);
    checkOutput("t1_wb", 64'(out_rec.wb), 64'd1);
    checkOutput("t1_wdata", 64'(out_rec.wdata), 64'h1234);
    applyStimulus(1'b0, 64'd0, 32'h0, 5'd0, 32'h0, 1'b1);
    checkOutput("t1_drained_count", 64'(count), 64'd0);
    checkOutput("t1_drained_valid", 64'(out_valid), 64'd0);

    // x0 destination: no write-back recorded; head held while not ready.
    ret_trap = 1'b1;
    applyStimulus(1'b1, 64'd1, 32'h8000_0004, 5'd0, 32'hDEAD, 1'b0);
    ret_trap = 1'b0;
    checkOutput("x0_wb", 64'(out_rec.wb), 64'd0);
    checkOutput("x0_wdata", 64'(out_rec.wdata), 64'd0);
    checkOutput("x0_trap", 64'(out_rec.trap), 64'd1);
    applyStimulus(1'b0, 64'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    checkOutput("hold_pc", 64'(out_rec.pc), 64'h8000_0004);
    checkOutput("hold_count", 64'(count), 64'd1);
    applyStimulus(1'b0, 64'd0, 32'h0, 5'd0, 32'h0, 1'b1);
    checkOutput("x0_drained", 64'(count), 64'd0);
    applyStimulus(1'b0, 64'd0, 32'h0, 5'd0, 32'h0, 1'b1);
    checkOutput("empty_pop_count", 64'(count), 64'd0);
    checkOutput("empty_pop_valid", 64'(out_valid), 64'd0);

    // Overflow: ten retirements into an 8-deep FIFO with no consumer.
    for (int i = 2; i < 12; i++)
      applyStimulus(1'b1, 64'(i), 32'h8000_0000 + 32'(4 * i), 5'd1, 32'(i), 1'b0);
    checkOutput("ovf_count", 64'(count), 64'd8);
    checkOutput("ovf_flag", 64'(overflow), 64'd1);
    checkOutput("ovf_drop", 64'(drop_cnt), 64'd2);
    checkOutput("ovf_head", out_rec.order, 64'd2);

    // Full with simultaneous push and pop.
    applyStimulus(1'b1, 64'd12, 32'h8000_0030, 5'd1, 32'd12, 1'b1);
    checkOutput("fullpp_count", 64'(count), 64'd8);
    checkOutput("fullpp_drop", 64'(drop_cnt), 64'd2);
    checkOutput("fullpp_head", out_rec.order, 64'd3);

    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("drain_%0d", k), out_rec.order, drain_orders[k]);
      applyStimulus(1'b0, 64'd0, 32'h0, 5'd0, 32'h0, 1'b1);
    end
    checkOutput("drain_empty", 64'(count), 64'd0);
    checkOutput("overflow_sticky", 64'(overflow), 64'd1);

    // Order gap 13,14,16,17.
    applyStimulus(1'b1, 64'd13, 32'h8000_0034, 5'd2, 32'd13, 1'b1);
    applyStimulus(1'b1, 64'd14, 32'h8000_0038, 5'd2, 32'd14, 1'b1);
    checkOutput("gap_none_yet", 64'(order_err), 64'd0);
    applyStimulus(1'b1, 64'd16, 32'h8000_0040, 5'd2, 32'd16, 1'b1);
    checkOutput("gap_flag", 64'(order_err), 64'(exp_err));
    checkOutput("gap_value", err_order, exp_err ? 64'd16 : 64'd0);
    applyStimulus(1'b1, 64'd17, 32'h8000_0044, 5'd2, 32'd17, 1'b1);
    checkOutput("gap_sticky", 64'(order_err), 64'(exp_err));
    checkOutput("gap_first_kept", err_order, exp_err ? 64'd16 : 64'd0);
    checkOutput("gap_stream_count", 64'(count), 64'd1);
    applyStimulus(1'b0, 64'd0, 32'h0, 5'd0, 32'h0, 1'b1);

    // Reset mid-stream with five queued records and a retirement during reset.
    for (int i = 20; i < 25; i++)
      applyStimulus(1'b1, 64'(i), 32'h8000_0100, 5'd3, 32'(i), 1'b0);
    checkOutput("mid_count", 64'(count), 64'd5);
    rst_n = 1'b0;
    applyStimulus(1'b1, 64'd99, 32'h8000_0200, 5'd3, 32'd99, 1'b0);
    rst_n = 1'b1;
    ret_valid = 1'b0;
    checkOutput("mrst_count", 64'(count), 64'd0);
    checkOutput("mrst_valid", 64'(out_valid), 64'd0);
    checkOutput("mrst_overflow", 64'(overflow), 64'd0);
    checkOutput("mrst_drop", 64'(drop_cnt), 64'd0);
    checkOutput("mrst_order_err", 64'(order_err), 64'd0);
    checkOutput("mrst_err_order", err_order, 64'd0);
    checkOutput("mrst_rec_zero", 64'(|out_rec), 64'd0);

    applyStimulus(1'b1, 64'd50, 32'h8000_0300, 5'd4, 32'd50, 1'b0);
    applyStimulus(1'b1, 64'd51, 32'h8000_0304, 5'd4, 32'd51, 1'b0);
    ret_valid = 1'b0;
    checkOutput("base_count", 64'(count), 64'd2);
    checkOutput("base_head", out_rec.order, 64'd50);
    checkOutput("base_no_err", 64'(order_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rvvi_trace_fifo.md
RVVI_TRACE_FIFO -- requirements
Module: rvvi_trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning trace record slots; power of two, at least 2.
REQ-002 SHALL have parameter ORDER_W, default 64, meaning width of the retirement order field.
REQ-003 SHALL have clk_i  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n_i  input  1  meaning reset; synchronous, active-low.
REQ-005 SHALL have ret_valid_i  input  1  meaning one retirement this cycle, RVFI valid.
REQ-006 SHALL have ret_order_i  input  ORDER_W  meaning retirement order number.
REQ-007 SHALL have ret_pc_i, ret_insn_i  input  32 each  meaning retired PC and instruction word.
REQ-008 SHALL have ret_trap_i  input  1  meaning the retired instruction trapped.
REQ-009 SHALL have ret_rd_addr_i  input  5 and ret_rd_wdata_i  input  32  meaning the X-register destination and its write value.
REQ-010 SHALL have out_valid_o  output  1 and out_ready_i  input  1  meaning the consumer handshake; transfer when both are high.
REQ-011 SHALL have out_rec_o  output  trace_rec_t  meaning the head record.
REQ-012 SHALL have count_o  output  $clog2(DEPTH)+1  meaning the current occupancy.
REQ-013 SHALL have overflow_o  output  1 and drop_cnt_o  output  16  meaning a sticky overflow flag and the number of dropped records.
REQ-014 SHALL have order_err_o  output  1 and err_order_o  output  ORDER_W  meaning a sticky order-gap flag and the first offending order value.

Function
REQ-015 SHALL push a record built from the ret_* inputs when ret_valid_i is high and the FIFO is not full, or is full while a pop occurs in the same cycle.
REQ-016 SHALL set the record wb field to 1 only when ret_rd_addr_i != 0; when the address is 0, wb and wdata SHALL be stored as 0.
REQ-017 SHALL present the head record show-ahead: out_valid_o = (count != 0), and out_rec_o is valid whenever out_valid_o is high.
REQ-018 SHALL make a record pushed in cycle N visible at the output in cycle N+1 when the FIFO was empty; there is no combinational path from ret_* to out_*.
REQ-019 SHALL hold out_rec_o stable while out_valid_o is high and out_ready_i is low.
REQ-020 SHALL, on a push and pop in the same cycle, leave count unchanged and replace the head correctly, including when count is 1 or DEPTH.
REQ-021 SHALL, on ret_valid_i while full with no pop, drop the record, set overflow_o, and increment drop_cnt_o, saturating at 0xFFFF.
REQ-022 SHALL wrap read and write pointers modulo DEPTH using an extra wrap bit for the full/empty distinction.
REQ-023 SHALL ignore out_ready_i when the FIFO is empty, with no underflow and no pointer change.
REQ-024 SHALL keep overflow_o and order_err_o set until reset.

Reset
REQ-025 SHALL, while rst_n_i is low at a clock edge, clear the pointers, count_o, out_valid_o, overflow_o, drop_cnt_o, order_err_o, err_order_o, and the order-check armed state.
REQ-026 SHALL drive out_rec_o as don't-care-free zero after reset, with the storage head zeroed.
REQ-027 SHALL, on reset asserted mid-operation, discard all queued records with no pop handshake.
REQ-028 SHALL, while reset is asserted, ignore ret_valid_i and not push.

Configuration
REQ-029 SHALL, with RVVI_ORDER_CHECK_EN defined, keep an expected-order register that is armed by the first ret_valid_i after reset with expected = order+1.
REQ-030 SHALL, with RVVI_ORDER_CHECK_EN defined, on each subsequent ret_valid_i with order != expected: set order_err_o, capture err_order_o only on the first error, and then set expected = order+1.
REQ-031 SHALL perform the order check on every retirement, including dropped ones.
REQ-032 SHALL, with RVVI_ORDER_CHECK_EN undefined, tie order_err_o and err_order_o to 0 and instantiate no order-check logic.

Structure
REQ-033 SHALL define trace_rec_t (order, pc, insn, trap, rd_addr, wb, wdata) in package rvvi_trace_pkg.
REQ-034 SHALL use the storage sub-module trace_fifo, a generic synchronous show-ahead FIFO parameterised by DEPTH and the record type width.
REQ-035 SHALL keep the order check and the drop counter in the top-level module.

Verification
REQ-036 SHALL cover single retire/drain: push order=0, pc=0x80000000, rd=5, wdata=0x1234, ready high -> out_valid_o high the next cycle with matching fields, wb=1, count back to 0.
REQ-037 SHALL cover x0 write: rd=0, wdata=0xDEAD -> record wb=0, wdata=0.
REQ-038 SHALL cover overflow: DEPTH=8, ready low, 10 retirements -> count=8, overflow_o=1, drop_cnt_o=2; then the drain yields orders 0..7 in sequence.
REQ-039 SHALL cover full with simultaneous push/pop: ready high and retirement together -> count stays 8, no drop, order preserved.
REQ-040 SHALL cover order gap with RVVI_ORDER_CHECK_EN: orders 0,1,3,4 -> order_err_o set at the retirement of 3, err_order_o=3, and no further error on 4.
REQ-041 SHALL cover reset mid-stream: 5 queued records, rst_n_i low for 1 cycle -> count_o=0, out_valid_o=0, flags cleared, and the next order is accepted as the new baseline.
